// File: rtl/lc3_mem_ctrl.sv
// Wait-state memory responder for the lc3 core: serves reads and writes from an internal array after a fixed latency.
// Optional macro LC3_MEM_RAND_WAIT_EN adds 0..3 LFSR-chosen extra wait cycles per request and the dbg_extra_wait output.
module lc3_mem_ctrl #(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 16,
    parameter int MEM_AW    = 12,
    parameter int READ_LAT  = 3,
    parameter int WRITE_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              memEN,
    input  logic              memWE,
    input  logic [ADDR_W-1:0] memory_addr,
    input  logic [DATA_W-1:0] memory_din,
    output logic [DATA_W-1:0] memory_dout,
    output logic              memRDY,
`ifdef LC3_MEM_RAND_WAIT_EN
    output logic [1:0]        dbg_extra_wait,
`endif
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    localparam int CNT_W = 5;
    localparam logic [CNT_W-1:0] READ_LOAD  = CNT_W'(READ_LAT);
    localparam logic [CNT_W-1:0] WRITE_LOAD = CNT_W'(WRITE_LAT);

    state_t              state;
    logic [CNT_W-1:0]    count;
    logic [CNT_W-1:0]    load_val;
    logic [MEM_AW-1:0]   addr;
    logic [DATA_W-1:0]   din_q;
    logic                we;
    logic                finish;
    logic [DATA_W-1:0]   mem [0:(1<<MEM_AW)-1];

    // Upper address bits alias away; they are intentionally not decoded.
    logic unused_addr_bits;
    assign unused_addr_bits = ^memory_addr[ADDR_W-1:MEM_AW];

    assign finish = (state == WAIT) && (count == '0);

`ifdef LC3_MEM_RAND_WAIT_EN
    logic [15:0] lfsr;
    logic        lfsr_fb;

    assign lfsr_fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) lfsr <= 16'hACE1;
        else      lfsr <= {lfsr[14:0], lfsr_fb};
    end

    always_comb begin
        load_val = (memWE ? WRITE_LOAD : READ_LOAD) + {{(CNT_W-2){1'b0}}, lfsr[1:0]};
    end
`else
    always_comb begin
        load_val = memWE ? WRITE_LOAD : READ_LOAD;
    end
`endif

    // The counter starts at LAT rather than LAT-1 so that the array access
    // cycle is included and memRDY lands LAT+1 edges after acceptance.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            count       <= '0;
            addr        <= '0;
            din_q       <= '0;
            we          <= 1'b0;
            memory_dout <= '0;
            memRDY      <= 1'b0;
            busy        <= 1'b0;
`ifdef LC3_MEM_RAND_WAIT_EN
            dbg_extra_wait <= 2'd0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    memRDY <= 1'b0;
                    if (memEN) begin
                        addr  <= memory_addr[MEM_AW-1:0];
                        din_q <= memory_din;
                        we    <= memWE;
                        count <= load_val;
                        busy  <= 1'b1;
                        state <= WAIT;
`ifdef LC3_MEM_RAND_WAIT_EN
                        dbg_extra_wait <= lfsr[1:0];
`endif
                    end
                end
                WAIT: begin
                    if (count == '0) begin
                        if (!we) memory_dout <= mem[addr];
                        memRDY <= 1'b1;
                        state  <= DONE;
                    end else begin
                        count <= count - 1'b1;
                    end
                end
                DONE: begin
                    memRDY <= 1'b0;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    memRDY <= 1'b0;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    // The array is never reset; a reset during WAIT leaves state IDLE so the write is dropped.
    always_ff @(posedge clk) begin
        if (finish && we) mem[addr] <= din_q;
    end

    a_we_known: assert property (@(posedge clk) disable iff (!rst)
        (state == IDLE && memEN) |-> !$isunknown(memWE));

endmodule
